md5_block_packer: RTL and testbench
===================================

Name: md5_block_packer

Overview:
- Sits directly downstream of the guess generator and upstream of the MD5 core.
- Accepts one left-justified ASCII guess per cycle, together with its length.
- Emits a fully padded single 512-bit MD5 message block: message bytes, 0x80, zero fill, then the 64-bit little-endian bit length.
- Two-stage valid/ready pipeline, full throughput of one block per cycle.

Parameters:
- MAX_LEN, 16: maximum guess length in bytes. Must be at most 55.
- CNT_W, 48: width of the emitted-block counter.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream guess is valid this cycle.
- in_ready  out  1  packer can accept a guess this cycle.
- in_guess  in  8*MAX_LEN  guess; byte 0 in [8*MAX_LEN-1 -: 8], later bytes toward the LSB.
- in_len  in  5  guess length in bytes.
- in_last  in  1  marks the final guess of the keyspace (generator done).
- out_valid  out  1  out_block is valid.
- out_ready  in  1  MD5 core accepts the block.
- out_block  out  512  padded block; byte i at [8*i+7:8*i], so MD5 word M[j] = [32*j+31:32*j].
- out_last  out  1  in_last carried alongside its guess.
- block_count  out  CNT_W  number of blocks accepted by downstream since reset.

Behaviour:
- Reset values: out_valid=0, out_block=0, out_last=0, block_count=0, both stage-valid flags 0. in_ready=0 during the reset cycle, then 1.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Stage 1 registers:
  - the byte-reversed guess (byte i moved to little-endian lane i);
  - the clamped length L = min(in_len, MAX_LEN);
  - last;
  - valid.
- Stage 2 builds the block from the stage-1 registers:
  - byte i = guess byte i for i<L;
  - byte L = 0x80;
  - bytes L+1..55 = 0x00;
  - bytes 56..63 = 64-bit little-endian value L*8 (only byte 56 can be non-zero, since L<=16 → max 0x80);
  - registers out_block, out_last, out_valid.
- Guess bytes at positions >= L are ignored even if non-zero, including 0x00 content from the full-ASCII charset. Length comes only from in_len, never from scanning for NUL.
- Latency: a guess accepted at cycle N appears with out_valid=1 at cycle N+2 when there is no stall.
- Stall rule: a stage advances when its downstream slot is empty or being drained this cycle.
  - stage2_en = !out_valid || out_ready
  - stage1_en = !s1_valid || stage2_en
  - in_ready = stage1_en (combinational; no combinational path from in_valid to in_ready).
- Backpressure holds: out_block and out_last are stable while out_valid && !out_ready. With sustained stall, at most 2 guesses are buffered, then in_ready=0.
- No loss, no duplication, strict order preserved.
- Empty pipeline: out_valid stays 0 and out_block holds its last value; downstream must qualify with valid.
- block_count increments by 1 on each output transfer. It wraps modulo 2^CNT_W without a flag.
- Simultaneous input and output transfer with both stages full: pipeline shifts, occupancy unchanged.
- in_len > MAX_LEN (17..31): clamped to MAX_LEN, i.e. identical to a length-MAX_LEN guess.
- in_len = 0: block is byte0=0x80, everything else 0.
- Reset asserted mid-operation: all buffered guesses are discarded, outputs return to reset values on the next edge, and block_count clears. Reset wins over any simultaneous transfer.

Decomposition:
- Shared package holds:
  - MD5_BLOCK_BITS = 512
  - MD5_PAD_BYTE = 8'h80
  - MD5_LEN_BYTE_OFFSET = 56
  - MAX_GUESS_LEN = 16
  - a function giving the clamped length.
- One natural sub-module: pipe_slice, a single valid/ready register stage parameterised by payload width, instantiated twice.
- Padding and masking logic stays inline in md5_block_packer.

Test Plan:
- "abc", in_len=3, out_ready=1 → at N+2 out_valid=1; M[0]=32'h80636261; byte56=0x18; all other bytes 0; block_count=1 after transfer.
- 16×'a', in_len=16 → bytes 0..15=0x61, byte16=0x80, byte56=0x80, rest 0.
- in_len=0, guess=all 0xFF → byte0=0x80, every other byte 0. Also in_len=20 with 16×'z' → identical to the in_len=16 result.
- Three back-to-back guesses "a","b","c" with out_ready=0 for 6 cycles:
  - in_ready drops after 2 accepted;
  - out_block holds the "a" block stable;
  - after release, the order is a,b,c with no gaps;
  - block_count=3.
- Continuous in_valid and random out_ready over 1000 guesses:
  - scoreboard reference-model match;
  - out_last seen only on the final guess;
  - block_count equals the number of output transfers.
- Reset pulsed for 1 cycle with both stages full → next cycle out_valid=0, block_count=0, in_ready=1, and no stale block emitted afterward.

Source files
------------

// File: rtl/md5_block_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md5_block_packer_pkg
// Description : Shared constants and helpers for the MD5 single-block packer.
// Revision    : 1.0 - initial release
// ============================================================================
package md5_block_packer_pkg;

    localparam int          MD5_BLOCK_BITS      = 512;
    localparam logic [7:0]  MD5_PAD_BYTE        = 8'h80;
    localparam int          MD5_LEN_BYTE_OFFSET = 56;
    localparam int          MAX_GUESS_LEN       = 16;

    // Internal length width: enough to hold any legal MAX_LEN (<= 55).
    localparam int          LEN_W               = 6;

    // Length seen by the padder: the requested length, capped at max_len.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [4:0] len,
                                                   input int         max_len);
        logic [LEN_W-1:0] r;
        if (int'(len) > max_len) begin
            r = LEN_W'(max_len);
        end else begin
            r = {1'b0, len};
        end
        return r;
    endfunction

endpackage : md5_block_packer_pkg
`default_nettype wire

// File: rtl/md5_block_packer_pipe_slice.sv
`default_nettype none
// ============================================================================
// Module      : md5_block_packer_pipe_slice
// Description : One valid/ready register stage. Accepts a new word whenever
//               the slot is empty or is being drained in the same cycle, so a
//               chain of slices sustains one transfer per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module md5_block_packer_pipe_slice #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             up_valid_i,
    output logic             up_ready_o,
    input  logic [WIDTH-1:0] up_data_i,
    output logic             dn_valid_o,
    input  logic             dn_ready_i,
    output logic [WIDTH-1:0] dn_data_o
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    assign up_ready_o = !valid_q || dn_ready_i;
    assign dn_valid_o = valid_q;
    assign dn_data_o  = data_q;

    // Next state: load when advancing; payload only changes on a real word so
    // an emptied slot keeps presenting its last value.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (up_ready_o) begin
            valid_d = up_valid_i;
            if (up_valid_i) begin
                data_d = up_data_i;
            end
        end
    end

    // Stage register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule : md5_block_packer_pipe_slice
`default_nettype wire

// File: rtl/md5_block_packer.sv
`default_nettype none
// ============================================================================
// Module      : md5_block_packer
// Description : Turns a left-justified ASCII guess plus its length into one
//               fully padded 512-bit MD5 message block. Two register stages:
//               stage 1 holds the byte-reversed guess and clamped length,
//               stage 2 holds the finished block.
// Revision    : 1.0 - initial release
// ============================================================================
module md5_block_packer
    import md5_block_packer_pkg::*;
#(
    parameter int MAX_LEN = MAX_GUESS_LEN,
    parameter int CNT_W   = 48
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [8*MAX_LEN-1:0]      in_guess,
    input  logic [4:0]                in_len,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MD5_BLOCK_BITS-1:0] out_block,
    output logic                      out_last,
    output logic [CNT_W-1:0]          block_count
);

    localparam int GUESS_W = 8 * MAX_LEN;
    localparam int S1_W    = GUESS_W + LEN_W + 1;
    localparam int S2_W    = MD5_BLOCK_BITS + 1;

    // Stage-1 payload fields
    logic [GUESS_W-1:0]        guess_le_d;
    logic [S1_W-1:0]           s1_data_d;
    logic [S1_W-1:0]           s1_data_q;
    logic                      s1_valid_q;
    logic                      s1_ready;
    logic [GUESS_W-1:0]        s1_guess_q;
    logic [LEN_W-1:0]          s1_len_q;
    logic                      s1_last_q;

    // Stage-2 payload
    logic [MD5_BLOCK_BITS-1:0] blk_d;
    logic [S2_W-1:0]           s2_data_q;
    logic                      s2_ready;
    logic                      s2_valid_q;

    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          cnt_d;

    // Guess byte 0 sits at the MSB end of the input; move byte i to lane i.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_byte_rev
            assign guess_le_d[8*gi +: 8] = in_guess[GUESS_W-1-8*gi -: 8];
        end
    endgenerate

    assign s1_data_d = {in_last, clamp_len(in_len, MAX_LEN), guess_le_d};

    md5_block_packer_pipe_slice #(
        .WIDTH (S1_W)
    ) u_stage1 (
        .clk        (clk),
        .reset      (reset),
        .up_valid_i (in_valid),
        .up_ready_o (s1_ready),
        .up_data_i  (s1_data_d),
        .dn_valid_o (s1_valid_q),
        .dn_ready_i (s2_ready),
        .dn_data_o  (s1_data_q)
    );

    // Nothing may be accepted while reset is being applied.
    assign in_ready = s1_ready && !reset;

    assign s1_guess_q = s1_data_q[GUESS_W-1:0];
    assign s1_len_q   = s1_data_q[GUESS_W +: LEN_W];
    assign s1_last_q  = s1_data_q[S1_W-1];

    // Block assembly: message bytes below L, pad byte at L, zeros elsewhere,
    // then the bit length little-endian in bytes 56..63. Bytes at or above L
    // are masked regardless of their content.
    always_comb begin
        blk_d = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(s1_len_q)) begin
                blk_d[8*i +: 8] = s1_guess_q[8*i +: 8];
            end
        end
        blk_d[{s1_len_q, 3'b000} +: 8] = MD5_PAD_BYTE;
        blk_d[MD5_BLOCK_BITS-1 -: 64]  = {55'd0, s1_len_q, 3'b000};
    end

    md5_block_packer_pipe_slice #(
        .WIDTH (S2_W)
    ) u_stage2 (
        .clk        (clk),
        .reset      (reset),
        .up_valid_i (s1_valid_q),
        .up_ready_o (s2_ready),
        .up_data_i  ({s1_last_q, blk_d}),
        .dn_valid_o (s2_valid_q),
        .dn_ready_i (out_ready),
        .dn_data_o  (s2_data_q)
    );

    assign out_valid = s2_valid_q;
    assign out_block = s2_data_q[MD5_BLOCK_BITS-1:0];
    assign out_last  = s2_data_q[S2_W-1];

    // Count blocks handed to the MD5 core; wraps silently.
    always_comb begin
        cnt_d = cnt_q;
        if (s2_valid_q && out_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Block counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign block_count = cnt_q;

endmodule : md5_block_packer
`default_nettype wire

// File: tb/tb_md5_block_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_md5_block_packer
// Description : Scoreboard bench for md5_block_packer. Stimulus pushes the
//               expected block on each accepted guess; a negedge monitor pops
//               and compares on each output transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md5_block_packer;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_guess = '0;
    logic [4:0]   in_len = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [511:0] out_block;
    logic         out_last;
    logic [47:0]  block_count;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [512:0] exp_q[$];
    logic [47:0]  exp_cnt = '0;
    logic         rand_ready = 1'b0;

    md5_block_packer dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_guess    (in_guess),
        .in_len      (in_len),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_block   (out_block),
        .out_last    (out_last),
        .block_count (block_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [512:0] act, input logic [512:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hand-built expectation: low bytes given literally, length byte at 56.
    function automatic logic [512:0] hand_blk(input logic [511:0] low, input logic [7:0] lenbits,
                                             input logic last);
        logic [511:0] b;
        b = low;
        b[455:448] = lenbits;
        return {last, b};
    endfunction

    // Reference padder used for the random run.
    function automatic logic [512:0] model(input logic [127:0] g, input logic [4:0] len,
                                          input logic last);
        logic [511:0] b;
        int L;
        b = '0;
        L = (int'(len) > 16) ? 16 : int'(len);
        for (int i = 0; i < L; i++) b[8*i +: 8] = g[127-8*i -: 8];
        b[8*L +: 8] = 8'h80;
        b[455:448] = 8'(L * 8);
        return {last, b};
    endfunction

    // Drive one guess until accepted; push its expected block at acceptance.
    task automatic send(input logic [127:0] g, input logic [4:0] len, input logic last,
                        input logic [512:0] exp);
        int t;
        t = 0;
        in_valid = 1'b1; in_guess = g; in_len = len; in_last = last;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: got in_ready=0 expected acceptance within 200 cycles");
        end else begin
            exp_q.push_back(exp);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Monitor: counter tracking and scoreboard pop on each output transfer.
    always @(negedge clk) begin
        if (reset) begin
            chk("in_ready_during_reset", 513'(in_ready), 513'(0));
            exp_q.delete();
            exp_cnt = '0;
        end else begin
            chk("block_count", 513'(block_count), 513'(exp_cnt));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_block: got block %0h expected none", out_block);
                end else begin
                    chk("block", {out_last, out_block}, exp_q.pop_front());
                end
                exp_cnt = exp_cnt + 48'd1;
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    logic [512:0] blk_a;

    initial begin
        int t;
        logic [127:0] g;
        logic [4:0]   l;

        // Reset for two cycles.
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 513'(out_valid), 513'(0));
        chk("reset_out_block", 513'({out_last, out_block}), 513'(0));
        chk("reset_in_ready", 513'(in_ready), 513'(1));
        @(posedge clk); #1;

        // "abc" with trailing garbage; latency and contents.
        out_ready = 1'b1;
        send({8'h61, 8'h62, 8'h63, {13{8'h41}}}, 5'd3, 1'b0,
             hand_blk(512'h80636261, 8'h18, 1'b0));
        @(negedge clk);
        chk("abc_latency_n1", 513'(out_valid), 513'(0));
        @(negedge clk);
        chk("abc_latency_n2", 513'(out_valid), 513'(1));
        chk("abc_word0", 513'(out_block[31:0]), 513'(32'h80636261));
        chk("abc_byte56", 513'(out_block[455:448]), 513'(8'h18));
        @(negedge clk);
        chk("abc_count", 513'(block_count), 513'(1));
        @(posedge clk); #1;

        // 16 x 'a', zero length with all-FF content, over-length 16 x 'z'.
        send({16{8'h61}}, 5'd16, 1'b0, hand_blk({8'h80, {16{8'h61}}}, 8'h80, 1'b0));
        send({16{8'hFF}}, 5'd0, 1'b0, hand_blk(512'h80, 8'h00, 1'b0));
        send({16{8'h7a}}, 5'd20, 1'b0, hand_blk({8'h80, {16{8'h7a}}}, 8'h80, 1'b0));
        repeat (4) @(posedge clk); #1;

        // Backpressure: a, b buffered, c held off.
        out_ready = 1'b0;
        blk_a = hand_blk(512'h8061, 8'h08, 1'b0);
        send({8'h61, 120'd0}, 5'd1, 1'b0, blk_a);
        send({8'h62, 120'd0}, 5'd1, 1'b0, hand_blk(512'h8062, 8'h08, 1'b0));
        in_valid = 1'b1; in_guess = {8'h63, 120'd0}; in_len = 5'd1; in_last = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 513'(in_ready), 513'(0));
            chk("stall_hold", {out_valid, out_block}, {1'b1, blk_a[511:0]});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send({8'h63, 120'd0}, 5'd1, 1'b0, hand_blk(512'h8063, 8'h08, 1'b0));
        @(negedge clk);
        chk("no_gap_b", 513'(out_valid), 513'(1));
        @(negedge clk);
        chk("no_gap_c", 513'(out_valid), 513'(1));
        @(negedge clk);
        chk("stall_count", 513'(block_count), 513'(7));
        @(posedge clk); #1;

        // Random backpressure over 1000 guesses, last flag on the final one.
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            g = {$urandom, $urandom, $urandom, $urandom};
            l = 5'($urandom_range(0, 31));
            send(g, l, (i == 999), model(g, l, (i == 999)));
        end
        in_last = 1'b0;
        rand_ready = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        chk("drain_empty", 513'(exp_q.size()), 513'(0));
        @(posedge clk); #1;

        // Reset with both stages full.
        out_ready = 1'b0;
        send({8'h71, 120'd0}, 5'd1, 1'b0, hand_blk(512'h8071, 8'h08, 1'b0));
        send({8'h72, 120'd0}, 5'd1, 1'b0, hand_blk(512'h8072, 8'h08, 1'b0));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_out_valid", 513'(out_valid), 513'(0));
        chk("post_reset_count", 513'(block_count), 513'(0));
        chk("post_reset_in_ready", 513'(in_ready), 513'(1));
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_stale_block", 513'(out_valid), 513'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_md5_block_packer
`default_nettype wire
